// File: rtl/ex_pkg.sv
// Shared opcodes, branch encodings and FSM states for the multi-cycle execute stage.
package ex_pkg;

    localparam int         SLBI_SHIFT = 8;
    localparam logic [4:0] BTR_CODE   = 5'd9;
    localparam logic [4:0] LBI_CODE   = 5'd10;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_XOR  = 5'd2,
        OP_ANDN = 5'd3,
        OP_ROL  = 5'd4,
        OP_SLL  = 5'd5,
        OP_ROR  = 5'd6,
        OP_SRL  = 5'd7,
        OP_SLBI = 5'd8,
        OP_BTR  = BTR_CODE,
        OP_LBI  = LBI_CODE,
        OP_SEQ  = 5'd11,
        OP_SLT  = 5'd12,
        OP_SLE  = 5'd13,
        OP_SCO  = 5'd14,
        OP_MUL  = 5'd16,
        OP_DIVU = 5'd17,
        OP_REMU = 5'd18
    } alu_op_e;

    localparam logic [1:0] BR_EQZ = 2'b00;
    localparam logic [1:0] BR_NEZ = 2'b01;
    localparam logic [1:0] BR_LTZ = 2'b10;
    localparam logic [1:0] BR_GEZ = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    function automatic logic is_md_op(alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative shift-add multiply / restoring divide, one step per cycle.
// acc holds the product or partial remainder, x the multiplicand or quotient.
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] acc, x, y;
    logic [CNT_W-1:0] cnt;
    logic             is_mul, is_rem;
    logic [WIDTH:0]   part, diff;
    logic             fit;

    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    assign part = {acc, x[WIDTH-1]};
    assign diff = part - {1'b0, y};
    assign fit  = ~diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            cnt    <= '0;
            is_mul <= 1'b0;
            is_rem <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            x      <= a;
            y      <= b;
            cnt    <= '0;
            is_mul <= (op == OP_MUL);
            is_rem <= (op == OP_REMU);
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (is_mul) begin
                if (y[0]) acc <= acc + x;
                x <= x << 1;
                y <= y >> 1;
            end else begin
                acc <= fit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
                x   <= {x[WIDTH-2:0], fit};
            end
        end
    end

    assign last        = (cnt == CNT_W'(WIDTH - 1));
    assign result      = (is_mul || is_rem) ? acc : x;
    assign div_by_zero = ~is_mul & (y == '0);

endmodule

// File: rtl/instr_execute_mc.sv
// Execute stage: forwarding, ALU, branch resolution and registered EX/MEM output.
// Define MULDIV_EN to build the iterative MUL/DIVU/REMU path and its stall FSM.
module instr_execute_mc
    import ex_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             mem_stall,
    input  logic [WIDTH-1:0] read_data_1,
    input  logic [WIDTH-1:0] read_data_2,
    input  logic [WIDTH-1:0] mem_forwarded,
    input  logic [WIDTH-1:0] wb_forwarded,
    input  logic             r1_mem_forward,
    input  logic             r1_wb_forward,
    input  logic             r2_mem_forward,
    input  logic             r2_wb_forward,
    input  logic [WIDTH-1:0] immediate,
    input  logic [4:0]       alu_op,
    input  logic             imm_use,
    input  logic             branch,
    input  logic             jump,
    input  logic             jr,
    input  logic [1:0]       branch_choose,
    input  logic [WIDTH-1:0] pc_add,
    output logic             stall_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] store_data,
    output logic             redirect,
    output logic [WIDTH-1:0] pc_next,
    output logic             err,
    output logic             div_by_zero
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int M    = WIDTH - 1;

    alu_op_e            op;
    logic [WIDTH-1:0]   op_a, op_b, op_bv;
    logic               accept, is_md;
    logic [WIDTH:0]     add_full;
    logic [WIDTH-1:0]   a_sub_b, alu_res, bit_rev;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [SH_W-1:0]    sh;
    logic               lt, eq;
    logic [WIDTH-1:0]   pc_sum, jr_tgt, pcn_d;
    logic               cond, take, pc_ovf;
    logic               md_load, md_issue, md_dbz;
    logic [WIDTH-1:0]   md_res, md_pc;

    assign op_a  = r1_mem_forward ? mem_forwarded : r1_wb_forward ? wb_forwarded : read_data_1;
    assign op_b  = r2_mem_forward ? mem_forwarded : r2_wb_forward ? wb_forwarded : read_data_2;
    assign op_bv = imm_use ? immediate : op_b;
    assign op    = alu_op_e'(alu_op);
    assign is_md = is_md_op(op);

    assign accept = in_valid & ~stall_out & ~mem_stall & ~flush;

    assign add_full = {1'b0, op_a} + {1'b0, op_bv};
    assign a_sub_b  = op_a - op_bv;
    // Signed less-than: sign of A-B, corrected when the subtraction overflows.
    assign lt       = a_sub_b[M] ^ ((op_a[M] ^ op_bv[M]) & (a_sub_b[M] ^ op_a[M]));
    assign eq       = (op_a == op_bv);
    assign sh       = op_bv[SH_W-1:0];
    assign rot_l    = {op_a, op_a} << sh;
    assign rot_r    = {op_a, op_a} >> sh;

    always_comb begin
        bit_rev = '0;
        for (int i = 0; i < WIDTH; i++) bit_rev[i] = op_a[M-i];
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = add_full[WIDTH-1:0];
            OP_SUB:  alu_res = op_bv - op_a;
            OP_XOR:  alu_res = op_a ^ op_bv;
            OP_ANDN: alu_res = op_a & ~op_bv;
            OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
            OP_SLL:  alu_res = op_a << sh;
            OP_ROR:  alu_res = rot_r[WIDTH-1:0];
            OP_SRL:  alu_res = op_a >> sh;
            OP_SLBI: alu_res = (op_a << SLBI_SHIFT) |
                               {{(WIDTH-SLBI_SHIFT){1'b0}}, immediate[SLBI_SHIFT-1:0]};
            OP_BTR:  alu_res = bit_rev;
            OP_LBI:  alu_res = op_bv;
            OP_SEQ:  alu_res[0] = eq;
            OP_SLT:  alu_res[0] = lt;
            OP_SLE:  alu_res[0] = lt | eq;
            OP_SCO:  alu_res[0] = add_full[WIDTH];
            default: alu_res = '0;
        endcase
    end

    assign pc_sum = pc_add + immediate;
    assign jr_tgt = op_a + immediate;
    assign pc_ovf = (pc_add[M] == immediate[M]) && (pc_sum[M] != pc_add[M]);

    always_comb begin
        cond = 1'b0;
        case (branch_choose)
            BR_EQZ: cond = (op_a == '0);
            BR_NEZ: cond = (op_a != '0);
            BR_LTZ: cond = op_a[M];
            BR_GEZ: cond = ~op_a[M];
            default: cond = 1'b0;
        endcase
    end

    assign take  = ~is_md & (jump | jr | (branch & cond));
    assign pcn_d = take ? (jr ? jr_tgt : pc_sum) : pc_add;

`ifdef MULDIV_EN
    md_state_e state_q, state_d;
    logic      md_start, md_step, md_last;

    assign stall_out = (state_q != IDLE);
    assign md_issue  = is_md;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            md_pc   <= '0;
        end else begin
            state_q <= state_d;
            if (md_start) md_pc <= pc_add;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_start = 1'b0;
        md_step  = 1'b0;
        md_load  = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept && is_md) begin
                    md_start = 1'b1;
                    state_d  = BUSY;
                end
                BUSY: begin
                    md_step = 1'b1;
                    if (md_last) state_d = DONE;
                end
                DONE: if (!mem_stall) begin
                    md_load = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    ex_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (md_start),
        .step        (md_step),
        .op          (op),
        .a           (op_a),
        .b           (op_bv),
        .last        (md_last),
        .result      (md_res),
        .div_by_zero (md_dbz)
    );
`else
    assign stall_out = 1'b0;
    assign md_issue  = 1'b0;
    assign md_load   = 1'b0;
    assign md_res    = '0;
    assign md_dbz    = 1'b0;
    assign md_pc     = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            store_data  <= '0;
            redirect    <= 1'b0;
            pc_next     <= '0;
            err         <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            redirect    <= 1'b0;
            err         <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (!mem_stall) begin
            if (md_load) begin
                out_valid   <= 1'b1;
                result      <= md_res;
                store_data  <= '0;
                redirect    <= 1'b0;
                pc_next     <= md_pc;
                err         <= 1'b0;
                div_by_zero <= md_dbz;
            end else if (accept && !md_issue) begin
                // With the MD path compiled out, MD opcodes land here and yield 0.
                out_valid   <= 1'b1;
                result      <= is_md ? '0 : alu_res;
                store_data  <= op_b;
                redirect    <= take;
                pc_next     <= pcn_d;
                err         <= ~is_md & (branch | jump) & pc_ovf;
                div_by_zero <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
